// File: rtl/viterbi_pkg.sv
// Shared constants and FSM encoding for the Viterbi traceback unit.
package viterbi_pkg;
  localparam int NSTATE     = 4;   // trellis states
  localparam int ST_W       = 2;   // state index width
  localparam int ID_W       = 3;   // symbol id width (ids wrap mod 8)
  localparam int NSYM       = 8;   // survivor memory depth in symbols
  localparam int PM_W_DEF   = 7;
  localparam int TB_LEN_DEF = 7;
  localparam int FILL_MAX   = 8;

  typedef enum logic [1:0] {IDLE, WALK, EMIT} tb_state_e;
endpackage

// File: rtl/tb_unit_if.sv
// Beat input / decoded-bit output bundle of the traceback unit.
interface tb_unit_if import viterbi_pkg::*; #(parameter int PM_W = PM_W_DEF);
  logic            data_rdy;
  logic [ID_W-1:0] data_id;
  logic [ST_W-1:0] addr_in;
  logic            dec_in;
  logic [PM_W-1:0] PM_in;
  logic            bit_out;
  logic            bit_vld;
  logic [ID_W-1:0] bit_id;
  logic            tb_busy;
  logic            ovf;
  logic            sym_err;

  modport master (output data_rdy, data_id, addr_in, dec_in, PM_in,
                  input  bit_out, bit_vld, bit_id, tb_busy, ovf, sym_err);
  modport slave  (input  data_rdy, data_id, addr_in, dec_in, PM_in,
                  output bit_out, bit_vld, bit_id, tb_busy, ovf, sym_err);
endinterface

// File: rtl/pm_min_track.sv
// Per-symbol running minimum path metric and its state; ties go to the lower state.
module pm_min_track import viterbi_pkg::*; #(
  parameter int PM_W = PM_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vld,
  input  logic            first,     // beat opens a fresh symbol
  input  logic [ST_W-1:0] addr,
  input  logic [PM_W-1:0] pm,
  output logic [ST_W-1:0] min_st_nxt // argmin including this beat
);
  logic [ST_W-1:0] run_st;
  logic [PM_W-1:0] run_pm;
  logic [PM_W-1:0] min_pm_nxt;
  logic            take;

  // Beat replaces the running winner if it is first, strictly lower, or ties on a lower state.
  always_comb begin
    take       = first || (pm < run_pm) || ((pm == run_pm) && (addr < run_st));
    min_st_nxt = take ? addr : run_st;
    min_pm_nxt = take ? pm   : run_pm;
  end

  // After a close these registers hold the closed symbol's best; the next beat
  // arrives with first=1 and restarts the search, which is the clear-on-close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_st <= '0;
      run_pm <= '0;
    end else if (vld) begin
      run_st <= min_st_nxt;
      run_pm <= min_pm_nxt;
    end
  end
endmodule

// File: rtl/tb_unit.sv
// Viterbi survivor memory + traceback: collects 4-state symbols, walks back
// TB_LEN symbols from the best state of each closed symbol and emits one bit.
module tb_unit import viterbi_pkg::*; #(
  parameter int PM_W   = PM_W_DEF,
  parameter int TB_LEN = TB_LEN_DEF
) (
  input  logic     TB_clk,
  input  logic     TB_rst,
  tb_unit_if.slave bus
);
  logic [NSYM-1:0][NSTATE-1:0] mem;
  logic [NSTATE-1:0] mask, mask_nxt;
  logic [ID_W-1:0]   cur_id, close_id, ptr;
  logic [3:0]        fill, fill_inc;
  logic [ST_W-1:0]   s, best_nxt;
  logic [2:0]        step;
  tb_state_e         state;
  logic              conflict, first, close, start;
  logic              bit_out_q, bit_vld_q, tb_busy_q, ovf_q, sym_err_q;
  logic [ID_W-1:0]   bit_id_q;

  // Symbol bookkeeping: abandon on id change, close when all states are seen.
  always_comb begin
    conflict = bus.data_rdy && (mask != '0) && (bus.data_id != cur_id);
    first    = conflict || (mask == '0);
    mask_nxt = (conflict ? '0 : mask) | (NSTATE'(1) << bus.addr_in);
    close    = bus.data_rdy && (mask_nxt == '1);
    fill_inc = (fill == 4'(FILL_MAX)) ? fill : fill + 4'd1;
    start    = close && (fill_inc == 4'(FILL_MAX)) && (state == IDLE);
  end

  pm_min_track #(.PM_W(PM_W)) u_min (
    .clk       (TB_clk),
    .rst_n     (TB_rst),
    .vld       (bus.data_rdy),
    .first     (first),
    .addr      (bus.addr_in),
    .pm        (bus.PM_in),
    .min_st_nxt(best_nxt)
  );

  // Beat intake: survivor write, seen-mask, fill level and sticky error flags.
  always_ff @(posedge TB_clk or negedge TB_rst) begin
    if (!TB_rst) begin
      mem       <= '0;
      mask      <= '0;
      cur_id    <= '0;
      fill      <= '0;
      ovf_q     <= 1'b0;
      sym_err_q <= 1'b0;
    end else if (bus.data_rdy) begin
      mem[bus.data_id][bus.addr_in] <= bus.dec_in;
      cur_id <= bus.data_id;
      if (conflict) sym_err_q <= 1'b1;
      if (close) begin
        mask <= '0;
        fill <= fill_inc;
        if (state != IDLE) ovf_q <= 1'b1;  // dropped, never queued
      end else begin
        mask <= mask_nxt;
      end
    end
  end

  // Traceback FSM: walk survivors backwards, then register one decoded bit.
  always_ff @(posedge TB_clk or negedge TB_rst) begin
    if (!TB_rst) begin
      state     <= IDLE;
      s         <= '0;
      ptr       <= '0;
      step      <= '0;
      close_id  <= '0;
      bit_out_q <= 1'b0;
      bit_vld_q <= 1'b0;
      bit_id_q  <= '0;
      tb_busy_q <= 1'b0;
    end else begin
      bit_vld_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= WALK;
          s         <= best_nxt;
          ptr       <= bus.data_id;
          close_id  <= bus.data_id;
          step      <= '0;
          tb_busy_q <= 1'b1;
        end
        WALK: begin
          // Survivor decision is the older input bit; shift it in as the new LSB.
          s    <= {s[0], mem[ptr][s]};
          ptr  <= ptr - 1'b1;
          step <= step + 3'd1;
          if (step == 3'(TB_LEN - 1)) state <= EMIT;
        end
        EMIT: begin
          bit_out_q <= s[1];
          bit_id_q  <= close_id - ID_W'(TB_LEN);
          bit_vld_q <= 1'b1;
          tb_busy_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bit_out = bit_out_q;
  assign bus.bit_vld = bit_vld_q;
  assign bus.bit_id  = bit_id_q;
  assign bus.tb_busy = tb_busy_q;
  assign bus.ovf     = ovf_q;
  assign bus.sym_err = sym_err_q;
endmodule
